// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register, req/ready imem handshake and pc_sel redirect.
// Optional macro DELAY_SLOT_EN: keep the word fetched on a redirecting edge as a MIPS delay slot.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic        in_stall,
  input  logic [1:0]  in_pc_sel,
  input  logic [31:0] in_branch_target,
  input  logic [31:0] in_jump_target,
  input  logic [31:0] in_jr_target,
  output logic        out_imem_req,
  output logic [31:0] out_imem_addr,
  input  logic [31:0] in_imem_rdata,
  input  logic        in_imem_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_id_instruction,
  output logic [31:0] out_id_pc,
  output logic [31:0] out_id_pc_plus4,
  output logic        out_id_valid
);

`ifdef DELAY_SLOT_EN
  localparam bit SlotEn = 1'b1;
`else
  localparam bit SlotEn = 1'b0;
`endif

  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic        pending_q, pending_d;
  logic [31:0] pending_target_q, pending_target_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] sel_raw;
  logic [31:0] sel_target;
  logic        fire;
  logic        redirect;

  assign pc_plus4 = pc_q + 32'd4;
  assign fire     = req_q & in_imem_ready;
  assign redirect = (in_pc_sel != 2'b00) & ~in_stall & ~pending_q;

  always_comb begin
    unique case (in_pc_sel)
      2'b01:   sel_raw = in_branch_target;
      2'b10:   sel_raw = in_jump_target;
      2'b11:   sel_raw = in_jr_target;
      default: sel_raw = pc_plus4;
    endcase
    sel_target = sel_raw & ~32'h0000_0003;
  end

  always_comb begin
    pc_d             = pc_q;
    req_d            = 1'b1;
    pending_d        = pending_q;
    pending_target_d = pending_target_q;
    id_instr_d       = id_instr_q;
    id_pc_d          = id_pc_q;
    id_pc_plus4_d    = id_pc_plus4_q;
    id_valid_d       = id_valid_q;

    if (in_stall) begin
      // Completion on a stalled edge is dropped; the same address is fetched again.
    end else if (!fire) begin
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
      if (redirect) begin
        pending_d        = 1'b1;
        pending_target_d = sel_target;
      end
    end else if (pending_q || redirect) begin
      pc_d      = pending_q ? pending_target_q : sel_target;
      pending_d = 1'b0;
      if (SlotEn) begin
        id_instr_d    = in_imem_rdata;
        id_pc_d       = pc_q;
        id_pc_plus4_d = pc_plus4;
        id_valid_d    = 1'b1;
      end else begin
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
      end
    end else begin
      pc_d          = pc_plus4;
      id_instr_d    = in_imem_rdata;
      id_pc_d       = pc_q;
      id_pc_plus4_d = pc_plus4;
      id_valid_d    = 1'b1;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      pc_q             <= RESET_PC;
      req_q            <= 1'b0;
      pending_q        <= 1'b0;
      pending_target_q <= 32'h0;
      id_instr_q       <= NOP_INSTR;
      id_pc_q          <= 32'h0;
      id_pc_plus4_q    <= 32'h0;
      id_valid_q       <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      req_q            <= req_d;
      pending_q        <= pending_d;
      pending_target_q <= pending_target_d;
      id_instr_q       <= id_instr_d;
      id_pc_q          <= id_pc_d;
      id_pc_plus4_q    <= id_pc_plus4_d;
      id_valid_q       <= id_valid_d;
    end
  end

  assign out_imem_req       = req_q;
  assign out_imem_addr      = pc_q;
  assign out_pc             = pc_q;
  assign out_id_instruction = id_instr_q;
  assign out_id_pc          = id_pc_q;
  assign out_id_pc_plus4    = id_pc_plus4_q;
  assign out_id_valid       = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, redirects, wait states, stall, wrap and reset.
module tb_fetch_stage;

  logic        in_clk = 1'b0;
  logic        in_rst_n;
  logic        in_stall;
  logic [1:0]  in_pc_sel;
  logic [31:0] in_branch_target;
  logic [31:0] in_jump_target;
  logic [31:0] in_jr_target;
  logic        out_imem_req;
  logic [31:0] out_imem_addr;
  logic [31:0] in_imem_rdata;
  logic        in_imem_ready;
  logic [31:0] out_pc;
  logic [31:0] out_id_instruction;
  logic [31:0] out_id_pc;
  logic [31:0] out_id_pc_plus4;
  logic        out_id_valid;

  int errs = 0;
  int checks = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  fetch_stage dut (
    .in_clk             (in_clk),
    .in_rst_n           (in_rst_n),
    .in_stall           (in_stall),
    .in_pc_sel          (in_pc_sel),
    .in_branch_target   (in_branch_target),
    .in_jump_target     (in_jump_target),
    .in_jr_target       (in_jr_target),
    .out_imem_req       (out_imem_req),
    .out_imem_addr      (out_imem_addr),
    .in_imem_rdata      (in_imem_rdata),
    .in_imem_ready      (in_imem_ready),
    .out_pc             (out_pc),
    .out_id_instruction (out_id_instruction),
    .out_id_pc          (out_id_pc),
    .out_id_pc_plus4    (out_id_pc_plus4),
    .out_id_valid       (out_id_valid)
  );

  always #5 in_clk = ~in_clk;

  // Instruction memory: each word is its address tagged in the upper half.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign in_imem_rdata = word_at(out_imem_addr);

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic test_reset();
    in_rst_n = 1'b0; in_stall = 1'b0; in_pc_sel = 2'b00; in_imem_ready = 1'b1;
    in_branch_target = 32'h0; in_jump_target = 32'h0; in_jr_target = 32'h0;
    repeat (2) step();
    checks++; if (out_imem_addr !== 32'h0) begin errs++; $display("FAIL reset_addr got=%h exp=%h", out_imem_addr, 32'h0); end
    checks++; if (out_imem_req !== 1'b0) begin errs++; $display("FAIL reset_req got=%b exp=0", out_imem_req); end
    checks++; if (out_id_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", out_id_valid); end
    checks++; if (out_id_instruction !== NOP) begin errs++; $display("FAIL reset_instr got=%h exp=%h", out_id_instruction, NOP); end
    #3 in_rst_n = 1'b1;
    step();
    checks++; if (out_imem_req !== 1'b1) begin errs++; $display("FAIL req_rise got=%b exp=1", out_imem_req); end
    checks++; if (out_imem_addr !== 32'h0) begin errs++; $display("FAIL first_addr got=%h exp=0", out_imem_addr); end
    checks++; if (out_id_valid !== 1'b0) begin errs++; $display("FAIL first_valid got=%b exp=0", out_id_valid); end
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (out_imem_addr !== 32'(4 * k)) begin errs++; $display("FAIL seq_addr k=%0d got=%h exp=%h", k, out_imem_addr, 32'(4 * k)); end
      checks++; if (out_id_instruction !== word_at(32'(4 * (k - 1)))) begin errs++; $display("FAIL seq_instr k=%0d got=%h exp=%h", k, out_id_instruction, word_at(32'(4 * (k - 1)))); end
      checks++; if (out_id_pc !== 32'(4 * (k - 1)) || out_id_pc_plus4 !== 32'(4 * k)) begin errs++; $display("FAIL seq_idpc k=%0d got=%h/%h", k, out_id_pc, out_id_pc_plus4); end
      checks++; if (out_id_valid !== 1'b1) begin errs++; $display("FAIL seq_valid k=%0d got=%b exp=1", k, out_id_valid); end
    end
  endtask

  task automatic test_branch();
    // PC is 0x10 here; ID holds the word from 0xC.
    in_pc_sel = 2'b01; in_branch_target = 32'h40;
    step();
    in_pc_sel = 2'b00;
    checks++; if (out_imem_addr !== 32'h40) begin errs++; $display("FAIL br_addr got=%h exp=40", out_imem_addr); end
`ifdef DELAY_SLOT_EN
    checks++; if (out_id_valid !== 1'b1 || out_id_instruction !== word_at(32'h10)) begin errs++; $display("FAIL br_slot got=%b/%h exp=1/%h", out_id_valid, out_id_instruction, word_at(32'h10)); end
`else
    checks++; if (out_id_valid !== 1'b0 || out_id_instruction !== NOP) begin errs++; $display("FAIL br_bubble got=%b/%h exp=0/%h", out_id_valid, out_id_instruction, NOP); end
    checks++; if (out_id_pc !== 32'hC) begin errs++; $display("FAIL br_bubble_pc got=%h exp=c", out_id_pc); end
`endif
    step();
    checks++; if (out_imem_addr !== 32'h44) begin errs++; $display("FAIL br_next_addr got=%h exp=44", out_imem_addr); end
    checks++; if (out_id_valid !== 1'b1 || out_id_instruction !== word_at(32'h40) || out_id_pc !== 32'h40) begin errs++; $display("FAIL br_target_word got=%b/%h/%h", out_id_valid, out_id_instruction, out_id_pc); end
  endtask

  task automatic test_pending_jump();
    in_pc_sel = 2'b11; in_jr_target = 32'h20;
    step();
    in_pc_sel = 2'b00;
    checks++; if (out_imem_addr !== 32'h20) begin errs++; $display("FAIL pj_setup got=%h exp=20", out_imem_addr); end
    in_imem_ready = 1'b0; in_pc_sel = 2'b10; in_jump_target = 32'h100;
    step();
    checks++; if (out_imem_addr !== 32'h20 || out_id_valid !== 1'b0) begin errs++; $display("FAIL pj_wait1 got=%h/%b exp=20/0", out_imem_addr, out_id_valid); end
    in_pc_sel = 2'b11; in_jr_target = 32'h200;
    step();
    checks++; if (out_imem_addr !== 32'h20) begin errs++; $display("FAIL pj_wait2 got=%h exp=20", out_imem_addr); end
    in_pc_sel = 2'b01; in_branch_target = 32'h300;
    step();
    checks++; if (out_imem_addr !== 32'h20) begin errs++; $display("FAIL pj_wait3 got=%h exp=20", out_imem_addr); end
    in_imem_ready = 1'b1; in_pc_sel = 2'b00;
    step();
    checks++; if (out_imem_addr !== 32'h100) begin errs++; $display("FAIL pj_target got=%h exp=100", out_imem_addr); end
`ifdef DELAY_SLOT_EN
    checks++; if (out_id_valid !== 1'b1 || out_id_instruction !== word_at(32'h20)) begin errs++; $display("FAIL pj_slot got=%b/%h", out_id_valid, out_id_instruction); end
`else
    checks++; if (out_id_valid !== 1'b0) begin errs++; $display("FAIL pj_bubble got=%b exp=0", out_id_valid); end
`endif
    step();
    checks++; if (out_imem_addr !== 32'h104 || out_id_instruction !== word_at(32'h100)) begin errs++; $display("FAIL pj_after got=%h/%h exp=104/%h", out_imem_addr, out_id_instruction, word_at(32'h100)); end
  endtask

  task automatic test_stall();
    in_stall = 1'b1; in_pc_sel = 2'b11; in_jr_target = 32'h80;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (out_imem_addr !== 32'h104) begin errs++; $display("FAIL stall_addr k=%0d got=%h exp=104", k, out_imem_addr); end
      checks++; if (out_id_instruction !== word_at(32'h100) || out_id_pc !== 32'h100 || out_id_valid !== 1'b1) begin errs++; $display("FAIL stall_ifid k=%0d got=%h/%h/%b", k, out_id_instruction, out_id_pc, out_id_valid); end
    end
    in_stall = 1'b0;
    step();
    in_pc_sel = 2'b00;
    checks++; if (out_imem_addr !== 32'h80) begin errs++; $display("FAIL stall_redirect got=%h exp=80", out_imem_addr); end
  endtask

  task automatic test_wrap();
    in_pc_sel = 2'b11; in_jr_target = 32'hFFFF_FFF8;
    step();
    in_pc_sel = 2'b00;
    step();
    checks++; if (out_imem_addr !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_pre got=%h exp=fffffffc", out_imem_addr); end
    step();
    checks++; if (out_imem_addr !== 32'h0) begin errs++; $display("FAIL wrap_addr got=%h exp=0", out_imem_addr); end
    checks++; if (out_id_pc !== 32'hFFFF_FFFC || out_id_pc_plus4 !== 32'h0) begin errs++; $display("FAIL wrap_idpc got=%h/%h exp=fffffffc/0", out_id_pc, out_id_pc_plus4); end
    in_pc_sel = 2'b11; in_jr_target = 32'h43;
    step();
    in_pc_sel = 2'b00;
    checks++; if (out_imem_addr !== 32'h40) begin errs++; $display("FAIL jr_align got=%h exp=40", out_imem_addr); end
  endtask

  task automatic test_reset_mid();
    in_imem_ready = 1'b0; in_pc_sel = 2'b10; in_jump_target = 32'h300;
    step();
    in_pc_sel = 2'b00;
    #3 in_rst_n = 1'b0;
    #1;
    checks++; if (out_imem_addr !== 32'h0 || out_imem_req !== 1'b0) begin errs++; $display("FAIL rstmid_pc got=%h/%b exp=0/0", out_imem_addr, out_imem_req); end
    checks++; if (out_id_valid !== 1'b0 || out_id_instruction !== NOP || out_id_pc !== 32'h0) begin errs++; $display("FAIL rstmid_ifid got=%b/%h/%h", out_id_valid, out_id_instruction, out_id_pc); end
    in_imem_ready = 1'b1;
    step();
    #3 in_rst_n = 1'b1;
    step();
    checks++; if (out_imem_addr !== 32'h0 || out_imem_req !== 1'b1) begin errs++; $display("FAIL rstmid_resume got=%h/%b exp=0/1", out_imem_addr, out_imem_req); end
    step();
    checks++; if (out_imem_addr !== 32'h4) begin errs++; $display("FAIL rstmid_nopending got=%h exp=4", out_imem_addr); end
    checks++; if (out_id_instruction !== word_at(32'h0) || out_id_valid !== 1'b1) begin errs++; $display("FAIL rstmid_word got=%h/%b", out_id_instruction, out_id_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_pending_jump();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the ID-stage decoder/controller.
- Holds the PC and drives a req/ready instruction-memory interface.
- Applies the controller's 2-bit pc_sel redirect (sequential / branch / jump / jr).
- Presents the fetched instruction to ID with hazard-unit stall and bubble insertion on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble instruction placed in IF/ID (decodes as sll $0,$0,0, pc_sel 00, no writes).

Ports:
- in_clk  input  1  clock, all state on rising edge.
- in_rst_n  input  1  reset, asynchronous, active-low.
- in_stall  input  1  hazard unit: hold PC and IF/ID this cycle.
- in_pc_sel  input  2  from controller: 00 PC+4, 01 branch taken, 10 jump, 11 jr.
- in_branch_target  input  32  branch target computed in ID.
- in_jump_target  input  32  {pc_plus4[31:28], instr_index, 2'b00} computed in ID.
- in_jr_target  input  32  forwarded rs value for jr.
- out_imem_req  output  1  fetch request.
- out_imem_addr  output  32  fetch address, equals PC register.
- in_imem_rdata  input  32  instruction word, valid when in_imem_ready=1.
- in_imem_ready  input  1  fetch completes on an edge where req and ready are both 1.
- out_pc  output  32  current fetch PC.
- out_id_instruction  output  32  IF/ID instruction to controller.
- out_id_pc  output  32  IF/ID PC of that instruction.
- out_id_pc_plus4  output  32  IF/ID PC+4.
- out_id_valid  output  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset (async, in_rst_n=0):
  - pc=RESET_PC; req_q=0; pending=0; pending_target=0.
  - IF/ID: instruction=NOP_INSTR, pc=0, pc_plus4=0, valid=0.
- out_imem_req=req_q. req_q goes to 1 on the first edge after reset release and stays 1.
- out_imem_addr=out_pc=pc, combinational from the register.
- Handshake: address is held stable while req=1 and ready=0; the PC changes only on a completing edge (req&ready&~stall).
- Redirect is valid when in_pc_sel!=00, in_stall=0 and pending=0. Target select: 01 branch, 10 jump, 11 jr. Target bits [1:0] are forced to 00.
- Per-edge priority, highest first:
  1. in_stall=1: pc, IF/ID, pending all hold. Redirect ignored, because ID holds the same instruction and re-presents it. A completion on this edge is discarded; the same address is re-fetched.
  2. ~ready: pc holds; IF/ID <= bubble (valid=0, instruction=NOP_INSTR). If a redirect is valid: pending<=1, pending_target<=selected target.
  3. ready and pending: pc<=pending_target; pending<=0; IF/ID per the delay-slot rule.
  4. ready and redirect valid: pc<=selected target; IF/ID per the delay-slot rule.
  5. ready, no redirect: pc<=pc+4; IF/ID <= {rdata, pc, pc+4}, valid=1.
- Delay-slot rule, default (macro off): the word fetched on a redirecting edge is wrong-path. IF/ID <= bubble. Taken branch/jump penalty is 1 cycle.
- While pending=1, in_pc_sel is ignored. ID holds a bubble, so the controller outputs 00 by construction.
- pc+4 arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Reset asserted mid-wait: pending is cleared, the PC returns to RESET_PC, and the in-flight fetch is abandoned.
- IF/ID pc/pc_plus4 fields of a bubble hold their previous values. Only instruction and valid are forced.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- Defined: MIPS branch-delay-slot semantics. On a redirecting edge (cases 3/4), the fetched word is the delay-slot instruction, and IF/ID <= {rdata, pc, pc+4}, valid=1. No bubble is inserted; zero redirect penalty.
- Undefined: bubble as described in Behaviour.

Test Plan:
- Reset then ready=1, pc_sel=00: imem_addr 0,4,8,C on consecutive cycles. ID shows each word one cycle later, valid=1. Valid=0 during reset.
- At pc=0x10, ID presents beq with pc_sel=01, target 0x40: next addr 0x40. ID valid=0 for one cycle, then the word from 0x40. With DELAY_SLOT_EN: ID gets the word from 0x10, valid=1.
- Hold ready=0 for 3 cycles at addr 0x20 with a jump (pc_sel=10, target 0x100) presented on the first cycle:
  - addr stays 0x20 and pending=1;
  - on ready, addr becomes 0x100;
  - pc_sel changes during the wait have no effect.
- in_stall=1 for 2 cycles with pc_sel=11, jr target 0x80: pc and IF/ID are unchanged and no redirect occurs. After the stall, the redirect to 0x80 takes effect.
- pc=0xFFFF_FFFC, sequential, ready=1: next addr 0x0000_0000. Misaligned jr target 0x0000_0043 gives addr 0x0000_0040.
- Assert in_rst_n=0 asynchronously mid-cycle with pending=1: outputs immediately at reset values, pending cleared. After release, fetch resumes at RESET_PC.
